// File: rtl/cpu_fetch_add_core.sv
// Single-issue fetch stage with a 32x32 register file that executes only the
// R-type ADD instruction; a debug port allows preloading and inspecting registers.
module cpu_fetch_add_core #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] PC_STEP  = 32'd1
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] instruction,
  output logic        is_add,
  output logic [31:0] alu_result,
  input  logic        dbg_we,
  input  logic [4:0]  dbg_waddr,
  input  logic [31:0] dbg_wdata,
  input  logic [4:0]  dbg_raddr,
  output logic [31:0] dbg_rdata
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [2:0] F3_ADD    = 3'b000;
  localparam logic [6:0] F7_ADD    = 7'b0000000;

  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] regs [32];

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  func3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  func7;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;

  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= RESET_PC;
      ir <= '0;
    end else begin
      pc <= pc + PC_STEP;
      ir <= imem_data;
    end
  end

  assign imem_addr   = pc;
  assign instruction = ir;

  always_comb begin
    opcode = ir[6:0];
    rd     = ir[11:7];
    func3  = ir[14:12];
    rs1    = ir[19:15];
    rs2    = ir[24:20];
    func7  = ir[31:25];
  end

  assign is_add = (opcode == OPC_OP) && (func3 == F3_ADD) && (func7 == F7_ADD);

  // x0 is forced to zero on every read port rather than relying on storage.
  always_comb begin
    rs1_val   = (rs1 == 5'd0) ? '0 : regs[rs1];
    rs2_val   = (rs2 == 5'd0) ? '0 : regs[rs2];
    dbg_rdata = (dbg_raddr == 5'd0) ? '0 : regs[dbg_raddr];
  end

  assign alu_result = is_add ? (rs1_val + rs2_val) : '0;

  // The add write is issued last so it overrides a debug write to the same register.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      if (dbg_we && (dbg_waddr != 5'd0)) regs[dbg_waddr] <= dbg_wdata;
      if (is_add && (rd != 5'd0))        regs[rd]        <= alu_result;
    end
  end

endmodule

// File: tb/tb_cpu_fetch_add_core.sv
// Self-checking bench for cpu_fetch_add_core: directed vector table, hand-written
// reset/collision/wrap sequences, and randomized traffic against a behavioural model.
module tb_cpu_fetch_add_core;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] instruction;
  logic        is_add;
  logic [31:0] alu_result;
  logic        dbg_we;
  logic [4:0]  dbg_waddr;
  logic [31:0] dbg_wdata;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;

  logic        use_word;
  logic [31:0] mem_word;

  logic        reset_w;
  logic [31:0] w_imem_addr, w_imem_data, w_instruction, w_alu_result, w_dbg_rdata;
  logic        w_is_add;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clock = ~clock;

  // Memory either echoes the address or returns a word chosen by the bench.
  assign imem_data   = use_word ? mem_word : imem_addr;
  assign w_imem_data = 32'd0;

  cpu_fetch_add_core dut (
    .clock(clock), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .instruction(instruction), .is_add(is_add), .alu_result(alu_result),
    .dbg_we(dbg_we), .dbg_waddr(dbg_waddr), .dbg_wdata(dbg_wdata),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  cpu_fetch_add_core #(.RESET_PC(32'hFFFF_FFFE), .PC_STEP(32'd1)) dut_wrap (
    .clock(clock), .reset(reset_w), .imem_addr(w_imem_addr), .imem_data(w_imem_data),
    .instruction(w_instruction), .is_add(w_is_add), .alu_result(w_alu_result),
    .dbg_we(1'b0), .dbg_waddr(5'd0), .dbg_wdata(32'd0),
    .dbg_raddr(5'd0), .dbg_rdata(w_dbg_rdata)
  );

  // Behavioural reference: architectural PC, instruction register and registers.
  logic [31:0] m_pc;
  logic [31:0] m_ir;
  logic [31:0] m_rf [32];

  function automatic bit m_is_add();
    return (m_ir[6:0] == 7'h33) && (m_ir[14:12] == 3'd0) && (m_ir[31:25] == 7'd0);
  endfunction

  function automatic logic [31:0] m_alu();
    if (!m_is_add()) return 32'd0;
    return m_rf[m_ir[19:15]] + m_rf[m_ir[24:20]];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // One clock: model consumes the inputs as they stand before the edge.
  task automatic tick();
    logic [31:0] fetched, sum;
    logic        do_add;
    logic [4:0]  rd;
    fetched = use_word ? mem_word : m_pc;
    do_add  = m_is_add();
    sum     = m_alu();
    rd      = m_ir[11:7];
    @(posedge clock);
    if (reset) begin
      m_pc = 32'd0;
      m_ir = 32'd0;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    end else begin
      if (dbg_we && dbg_waddr != 5'd0) m_rf[dbg_waddr] = dbg_wdata;
      if (do_add && rd != 5'd0)        m_rf[rd]        = sum;
      m_ir = fetched;
      m_pc = m_pc + 32'd1;
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".pc"},    imem_addr,          m_pc);
    chk({tag, ".ir"},    instruction,        m_ir);
    chk({tag, ".add"},   {31'd0, is_add},    {31'd0, m_is_add()});
    chk({tag, ".alu"},   alu_result,         m_alu());
    chk({tag, ".rdata"}, dbg_rdata,          m_rf[dbg_raddr]);
  endtask

  task automatic set_in(input logic r, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic uw, input logic [31:0] w,
                        input logic [4:0] ra);
    reset = r; dbg_we = we; dbg_waddr = wa; dbg_wdata = wd;
    use_word = uw; mem_word = w; dbg_raddr = ra;
  endtask

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        uw;
    logic [31:0] word;
    logic [4:0]  raddr;
    logic [31:0] e_pc;
    logic [31:0] e_ir;
    logic        e_add;
    logic [31:0] e_alu;
    logic [31:0] e_rdata;
  } vec_t;

  localparam logic [31:0] ADD1 = 32'h003100B3;  // add x1,x2,x3
  localparam logic [31:0] SUB1 = 32'h403100B3;  // sub x1,x2,x3
  localparam logic [31:0] ADD0 = 32'h00310033;  // add x0,x2,x3
  localparam logic [31:0] ADDC = 32'h007302B3;  // add x5,x6,x7

  vec_t tbl [15];

  initial begin
    reset_w = 1'b1;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_pc = 32'd0;
    m_ir = 32'd0;
    set_in(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd0);

    tbl[0]  = '{1'b1, 1'b0, 5'd0, 32'd0,         1'b0, 32'd0, 5'd0, 32'd0,  32'd0, 1'b0, 32'd0,  32'd0};
    tbl[1]  = '{1'b0, 1'b0, 5'd0, 32'd0,         1'b0, 32'd0, 5'd0, 32'd1,  32'd0, 1'b0, 32'd0,  32'd0};
    tbl[2]  = '{1'b0, 1'b0, 5'd0, 32'd0,         1'b0, 32'd0, 5'd0, 32'd2,  32'd1, 1'b0, 32'd0,  32'd0};
    tbl[3]  = '{1'b0, 1'b0, 5'd0, 32'd0,         1'b0, 32'd0, 5'd0, 32'd3,  32'd2, 1'b0, 32'd0,  32'd0};
    tbl[4]  = '{1'b0, 1'b1, 5'd2, 32'd5,         1'b0, 32'd0, 5'd2, 32'd4,  32'd3, 1'b0, 32'd0,  32'd5};
    tbl[5]  = '{1'b0, 1'b1, 5'd3, 32'd7,         1'b1, ADD1,  5'd3, 32'd5,  ADD1,  1'b1, 32'd12, 32'd7};
    tbl[6]  = '{1'b0, 1'b0, 5'd0, 32'd0,         1'b1, ADD1,  5'd1, 32'd6,  ADD1,  1'b1, 32'd12, 32'd12};
    tbl[7]  = '{1'b0, 1'b0, 5'd0, 32'd0,         1'b1, SUB1,  5'd1, 32'd7,  SUB1,  1'b0, 32'd0,  32'd12};
    tbl[8]  = '{1'b0, 1'b0, 5'd0, 32'd0,         1'b1, SUB1,  5'd1, 32'd8,  SUB1,  1'b0, 32'd0,  32'd12};
    tbl[9]  = '{1'b0, 1'b1, 5'd2, 32'd1,         1'b1, 32'd0, 5'd2, 32'd9,  32'd0, 1'b0, 32'd0,  32'd1};
    tbl[10] = '{1'b0, 1'b1, 5'd3, 32'd1,         1'b1, ADD0,  5'd0, 32'd10, ADD0,  1'b1, 32'd2,  32'd0};
    tbl[11] = '{1'b0, 1'b0, 5'd0, 32'd0,         1'b1, 32'd0, 5'd0, 32'd11, 32'd0, 1'b0, 32'd0,  32'd0};
    tbl[12] = '{1'b0, 1'b1, 5'd2, 32'hFFFF_FFFF, 1'b1, 32'd0, 5'd2, 32'd12, 32'd0, 1'b0, 32'd0,  32'hFFFF_FFFF};
    tbl[13] = '{1'b0, 1'b0, 5'd0, 32'd0,         1'b1, ADD1,  5'd1, 32'd13, ADD1,  1'b1, 32'd0,  32'd12};
    tbl[14] = '{1'b0, 1'b0, 5'd0, 32'd0,         1'b1, 32'd0, 5'd1, 32'd14, 32'd0, 1'b0, 32'd0,  32'd0};

    for (int i = 0; i < 15; i++) begin
      set_in(tbl[i].rst, tbl[i].we, tbl[i].waddr, tbl[i].wdata, tbl[i].uw, tbl[i].word, tbl[i].raddr);
      tick();
      chk($sformatf("vec%0d.pc", i),    imem_addr,       tbl[i].e_pc);
      chk($sformatf("vec%0d.ir", i),    instruction,     tbl[i].e_ir);
      chk($sformatf("vec%0d.add", i),   {31'd0, is_add}, {31'd0, tbl[i].e_add});
      chk($sformatf("vec%0d.alu", i),   alu_result,      tbl[i].e_alu);
      chk($sformatf("vec%0d.rdata", i), dbg_rdata,       tbl[i].e_rdata);
    end

    // Mid-run reset with an add and a debug write both pending.
    set_in(1'b0, 1'b1, 5'd2, 32'd5, 1'b1, 32'd0, 5'd1); tick();
    set_in(1'b0, 1'b1, 5'd3, 32'd7, 1'b1, ADD1,  5'd1); tick();
    set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, ADD1,  5'd1); tick();
    chk("rst_pre.x1", dbg_rdata, 32'd12);
    set_in(1'b1, 1'b1, 5'd4, 32'd77, 1'b1, ADD1, 5'd1); tick();
    chk("rst.pc",    imem_addr,       32'd0);
    chk("rst.ir",    instruction,     32'd0);
    chk("rst.add",   {31'd0, is_add}, 32'd0);
    chk("rst.alu",   alu_result,      32'd0);
    chk("rst.x1",    dbg_rdata,       32'd0);
    set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 32'd0, 5'd4); tick();
    chk("rst_post.pc", imem_addr, 32'd1);
    chk("rst_post.x4", dbg_rdata, 32'd0);
    check_model("rst_post");

    // Add and debug write to the same register, then to different registers.
    set_in(1'b0, 1'b1, 5'd6, 32'd10,  1'b1, 32'd0, 5'd6); tick();
    set_in(1'b0, 1'b1, 5'd7, 32'd20,  1'b1, ADDC,  5'd7); tick();
    set_in(1'b0, 1'b1, 5'd5, 32'd999, 1'b1, ADDC,  5'd5); tick();
    chk("coll.x5", dbg_rdata, 32'd30);
    set_in(1'b0, 1'b1, 5'd9, 32'd44,  1'b1, 32'd0, 5'd9); tick();
    chk("both.x9", dbg_rdata, 32'd44);
    set_in(1'b0, 1'b0, 5'd0, 32'd0,   1'b1, 32'd0, 5'd5); tick();
    chk("both.x5", dbg_rdata, 32'd30);
    check_model("coll");

    // PC wraparound on the instance reset near the top of the address space.
    reset_w = 1'b1; tick();
    chk("wrap.0", w_imem_addr, 32'hFFFF_FFFE);
    reset_w = 1'b0; tick();
    chk("wrap.1", w_imem_addr, 32'hFFFF_FFFF);
    tick();
    chk("wrap.2", w_imem_addr, 32'd0);
    tick();
    chk("wrap.3", w_imem_addr, 32'd1);

    for (int c = 0; c < 400; c++) begin
      logic [31:0] w;
      int unsigned sel;
      sel = $urandom_range(0, 99);
      if (sel < 50)
        w = {7'd0, 5'($urandom), 5'($urandom), 3'd0, 5'($urandom), 7'h33};
      else if (sel < 65)
        w = {7'($urandom_range(1, 127)), 5'($urandom), 5'($urandom), 3'd0, 5'($urandom), 7'h33};
      else if (sel < 75)
        w = {7'd0, 5'($urandom), 5'($urandom), 3'($urandom_range(1, 7)), 5'($urandom), 7'h33};
      else
        w = $urandom;
      set_in(($urandom_range(0, 49) == 0), 1'($urandom), 5'($urandom), $urandom,
             ($urandom_range(0, 9) != 0), w, 5'($urandom));
      tick();
      check_model($sformatf("rand%0d", c));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
